// File: rtl/irq_pending_ctrl.sv
// Synchronizes 4 request lines into sticky pending bits and presents the highest eligible index.
// Pending -> irq_valid in 1 cycle; irq_idx/irq_valid hold until irq_ready, with a bubble cycle between grants.
module irq_pending_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_in,
  input  logic [3:0] mask,
  output logic [1:0] irq_idx,
  output logic       irq_valid,
  input  logic       irq_ready,
  output logic [3:0] pending,
  output logic [3:0] overflow,
  input  logic       ovf_clr
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0][3:0] r_sync;
  logic [3:0] r_prev;
  logic [3:0] r_pend;
  logic [3:0] r_ovf;
  logic [1:0] r_idx;
  logic       r_valid;
  state_t     r_state;

  logic [3:0] w_s;
  logic [3:0] w_ev;
  logic       w_hs;
  logic [3:0] w_clr;
  logic [3:0] w_ovf_set;
  logic [3:0] w_elig;
  logic [1:0] w_sel;
  state_t     w_state_nxt;
  logic [1:0] w_idx_nxt;
  logic       w_valid_nxt;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_ev      = EDGE_MODE ? (w_s & ~r_prev) : w_s;
  assign w_hs      = r_valid & irq_ready;
  assign w_clr     = w_hs ? (4'b0001 << r_idx) : 4'b0000;
  // A re-arming event on the line being acknowledged is not an overflow.
  assign w_ovf_set = EDGE_MODE ? (w_ev & r_pend & ~w_clr) : 4'b0000;
  assign w_elig    = r_pend & mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 4'b0000;
      r_pend <= 4'b0000;
      r_ovf  <= 4'b0000;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], req_in};
      r_prev <= w_s;
      r_pend <= w_ev | (r_pend & ~w_clr);
      r_ovf  <= (r_ovf & ~{4{ovf_clr}}) | w_ovf_set;
    end
  end

  always_comb begin
    w_sel = 2'd0;
    if (w_elig[3])      w_sel = 2'd3;
    else if (w_elig[2]) w_sel = 2'd2;
    else if (w_elig[1]) w_sel = 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // No pre-emption or withdrawal once presenting; only the handshake leaves PRESENT.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    case (r_state)
      IDLE: begin
        w_valid_nxt = 1'b0;
        if (w_elig != 4'b0000) begin
          w_idx_nxt   = w_sel;
          w_valid_nxt = 1'b1;
          w_state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (w_hs) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign irq_idx   = r_idx;
  assign irq_valid = r_valid;
  assign pending   = r_pend;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: edge-mode instance plus a level-mode instance.
module tb_irq_pending_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_in, mask;
  logic       irq_ready, ovf_clr;
  logic [1:0] irq_idx;
  logic       irq_valid;
  logic [3:0] pending, overflow;

  logic [3:0] l_req, l_mask;
  logic       l_ready, l_ovf_clr;
  logic [1:0] l_idx;
  logic       l_valid;
  logic [3:0] l_pending, l_overflow;

  int checks;
  int failures;

  irq_pending_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask),
    .irq_idx(irq_idx), .irq_valid(irq_valid), .irq_ready(irq_ready),
    .pending(pending), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  irq_pending_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(1'b0)) u_lvl (
    .clk(clk), .rst_n(rst_n), .req_in(l_req), .mask(l_mask),
    .irq_idx(l_idx), .irq_valid(l_valid), .irq_ready(l_ready),
    .pending(l_pending), .overflow(l_overflow), .ovf_clr(l_ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    req_in    = 4'b0000;
    mask      = 4'b1111;
    irq_ready = 1'b0;
    ovf_clr   = 1'b0;
    l_req     = 4'b0000;
    l_mask    = 4'b1111;
    l_ready   = 1'b1;
    l_ovf_clr = 1'b0;

    #1;
    chk("rst_valid", {3'b000, irq_valid}, 4'b0000);
    chk("rst_pending", pending, 4'b0000);
    chk("rst_overflow", overflow, 4'b0000);
    step(2);
    rst_n = 1'b1;
    step(2);

    // Single event on line 1 with irq_ready high
    req_in = 4'b0010; irq_ready = 1'b1;
    step(2);
    chk("single_pend_e2", pending, 4'b0000);
    step(1);
    chk("single_pend_e3", pending, 4'b0010);
    chk("single_valid_e3", {3'b000, irq_valid}, 4'b0000);
    step(1);
    chk("single_valid_e4", {3'b000, irq_valid}, 4'b0001);
    chk("single_idx_e4", {2'b00, irq_idx}, 4'b0001);
    step(1);
    chk("single_valid_e5", {3'b000, irq_valid}, 4'b0000);
    chk("single_pend_e5", pending, 4'b0000);
    req_in = 4'b0000;
    step(4);

    // Simultaneous lines 0 and 2: line 2 first, bubble, then line 0
    req_in = 4'b0101;
    step(3);
    chk("prio_pend_e3", pending, 4'b0101);
    step(1);
    chk("prio_valid_e4", {3'b000, irq_valid}, 4'b0001);
    chk("prio_idx_e4", {2'b00, irq_idx}, 4'b0010);
    step(1);
    chk("prio_bubble_e5", {3'b000, irq_valid}, 4'b0000);
    chk("prio_pend_e5", pending, 4'b0001);
    step(1);
    chk("prio_valid_e6", {3'b000, irq_valid}, 4'b0001);
    chk("prio_idx_e6", {2'b00, irq_idx}, 4'b0000);
    step(1);
    chk("prio_valid_e7", {3'b000, irq_valid}, 4'b0000);
    chk("prio_pend_e7", pending, 4'b0000);
    req_in = 4'b0000;
    step(4);

    // Stability: line 3 arriving during a stalled presentation of line 0
    irq_ready = 1'b0; req_in = 4'b0001;
    step(4);
    chk("stab_valid", {3'b000, irq_valid}, 4'b0001);
    chk("stab_idx", {2'b00, irq_idx}, 4'b0000);
    req_in = 4'b1001;
    step(5);
    chk("stab_pend_both", pending, 4'b1001);
    chk("stab_idx_held", {2'b00, irq_idx}, 4'b0000);
    chk("stab_valid_held", {3'b000, irq_valid}, 4'b0001);
    irq_ready = 1'b1;
    step(1);
    chk("stab_bubble", {3'b000, irq_valid}, 4'b0000);
    chk("stab_pend_after", pending, 4'b1000);
    step(1);
    chk("stab_next_valid", {3'b000, irq_valid}, 4'b0001);
    chk("stab_next_idx", {2'b00, irq_idx}, 4'b0011);
    step(1);
    chk("stab_pend_clear", pending, 4'b0000);
    req_in = 4'b0000;
    step(4);

    // Overflow while line 0 is masked
    mask = 4'b1110; req_in = 4'b0001;
    step(4);
    chk("ovf_pend0", pending, 4'b0001);
    chk("ovf_masked_valid", {3'b000, irq_valid}, 4'b0000);
    chk("ovf_none_yet", overflow, 4'b0000);
    req_in = 4'b0000;
    step(3);
    req_in = 4'b0001;
    step(4);
    chk("ovf_set", overflow, 4'b0001);
    chk("ovf_valid_still0", {3'b000, irq_valid}, 4'b0000);
    mask = 4'b1111;
    step(1);
    chk("ovf_unmask_valid", {3'b000, irq_valid}, 4'b0001);
    chk("ovf_unmask_idx", {2'b00, irq_idx}, 4'b0000);
    step(1);
    chk("ovf_after_hs_pend", pending, 4'b0000);
    chk("ovf_sticky", overflow, 4'b0001);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 4'b0000);
    req_in = 4'b0000;
    step(4);

    // Level mode: repeated grants of line 2 separated by one bubble
    l_req = 4'b0100;
    step(4);
    for (int k = 0; k < 6; k++) begin
      chk("lvl_valid", {3'b000, l_valid}, (k % 2 == 0) ? 4'b0001 : 4'b0000);
      if (k % 2 == 0) chk("lvl_idx", {2'b00, l_idx}, 4'b0010);
      chk("lvl_overflow", l_overflow, 4'b0000);
      step(1);
    end
    l_req = 4'b0000;
    step(4);

    // Asynchronous reset in the middle of a presentation
    irq_ready = 1'b0; req_in = 4'b1010;
    step(4);
    chk("rstmid_valid_pre", {3'b000, irq_valid}, 4'b0001);
    chk("rstmid_idx_pre", {2'b00, irq_idx}, 4'b0011);
    chk("rstmid_pend_pre", pending, 4'b1010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", {3'b000, irq_valid}, 4'b0000);
    chk("rstmid_pend", pending, 4'b0000);
    chk("rstmid_ovf", overflow, 4'b0000);
    chk("rstmid_idx", {2'b00, irq_idx}, 4'b0000);
    req_in = 4'b0000;
    step(1);
    rst_n = 1'b1;
    step(6);
    chk("rstpost_valid", {3'b000, irq_valid}, 4'b0000);
    chk("rstpost_pend", pending, 4'b0000);
    chk("rstpost_ovf", overflow, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_pending_ctrl.md
Name: irq_pending_ctrl

Overview:
- Upstream request-capture stage that feeds the team's 4-to-2 priority encoding path.
- Synchronizes 4 asynchronous request lines and optionally edge-detects them.
- Holds the requests as sticky pending bits and applies a per-line enable mask.
- Presents the highest-priority eligible request index on a registered valid/ready interface; line 3 has highest priority, which is the same convention as the encoder (d[3] gives y=11). The pending bit is cleared on handshake.

Parameters:
- SYNC_STAGES, 2, depth of the input synchronizer flop chain per line (legal values ≥2).
- EDGE_MODE, 1, 1 = a rising edge of a synchronized line sets pending; 0 = a high level sets pending every cycle.

Ports:
- clk  input  1  single clock; all state on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_in  input  4  asynchronous request lines; bit i = source i.
- mask  input  4  synchronous enable; 1 = line eligible for presentation.
- irq_idx  output  2  index of the presented request.
- irq_valid  output  1  irq_idx is valid.
- irq_ready  input  1  consumer accepts irq_idx.
- pending  output  4  sticky pending bits (registered).
- overflow  output  4  sticky flag: an event arrived while that line was already pending.
- ovf_clr  input  1  synchronous clear of all overflow bits.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. rst_n low forces the following immediately, independent of clk:
  - all synchronizer flops, edge-history flops, pending, overflow, irq_idx = 0;
  - irq_valid = 0;
  - FSM = IDLE.
- Reset mid-transfer drops the presented request silently; there is no replay.
- Sync: req_in[i] passes through SYNC_STAGES flops to give s[i]. The previous value is held in p[i]. ev[i] = s[i] & ~p[i] when EDGE_MODE=1, ev[i] = s[i] when EDGE_MODE=0.
- Pending update per bit i, each cycle, in priority order:
  - ev[i] = 1 → pending[i] <= 1. This takes priority over clear on the same cycle.
  - otherwise, handshake (irq_valid & irq_ready) with irq_idx == i → pending[i] <= 0.
  - otherwise hold.
- Overflow per bit i:
  - set when ev[i] = 1 and pending[i] = 1, unless the same cycle is a handshake clearing bit i. In that case the new event simply re-arms pending and no overflow is flagged.
  - ovf_clr clears all bits. A set on the same cycle wins over ovf_clr.
  - In EDGE_MODE=0, overflow is never set. ev is ignored for overflow.
- Eligible vector e = pending & mask. The selected index is the highest set bit of e.
- FSM IDLE:
  - if e != 0: irq_idx <= selected index, irq_valid <= 1, go to PRESENT.
  - else stay, with irq_valid = 0.
- FSM PRESENT:
  - irq_idx and irq_valid are held stable until the handshake. There is no pre-emption by newly arriving higher-priority lines.
  - Clearing mask[irq_idx] while presenting does not withdraw the presentation.
  - On irq_valid & irq_ready: irq_valid <= 0, go to IDLE. There is always at least one cycle of irq_valid = 0 between consecutive grants.
- Latency, EDGE_MODE=1, from the first clk edge sampling req_in high:
  - s high after SYNC_STAGES edges;
  - pending set at edge SYNC_STAGES+1;
  - irq_valid high at edge SYNC_STAGES+2 (edge 4 at default).
- With irq_ready held high, a single request completes its handshake in the first cycle of valid. pending clears at the same edge that irq_valid falls.
- Masked pending bits stay pending and are presented once unmasked (after 1 cycle in IDLE).
- Level mode: a line still high after its handshake re-pends on the next cycle. This is the intended behaviour.
- Width rules: irq_idx is 2-bit. Index i is encoded as its binary value (line 0 → 00, line 3 → 11). There is no "none" code; irq_valid qualifies irq_idx.

Test Plan:
- Reset: assert rst_n=0 mid-PRESENT with pending=1010 → immediately irq_valid=0, pending=0000, overflow=0000. After release, outputs stay 0 with req_in=0.
- Single event (EDGE_MODE=1, SYNC_STAGES=2, mask=1111, irq_ready=1): req_in 0000→0010 held → pending[1]=1 at edge 3, irq_valid=1 with irq_idx=01 at edge 4. At edge 5: irq_valid=0 and pending=0000.
- Priority ordering: req_in 0000→0101 simultaneously, irq_ready=1 → grant irq_idx=10, then ≥1 bubble cycle, then irq_idx=00, then pending=0000.
- Stability/no pre-emption: presenting irq_idx=00 with irq_ready=0, then req_in[3] rises → irq_idx stays 00 until irq_ready=1. The next grant after the bubble is 11.
- Overflow and masking:
  - with mask=1110 and pending[0] set, pulse req_in[0] again (low ≥3 cycles, then high) → overflow=0001, irq_valid stays 0;
  - set mask=1111 → grant 00;
  - ovf_clr=1 → overflow=0000.
- Level mode (EDGE_MODE=0): hold req_in[2]=1, irq_ready=1 → repeated grants of irq_idx=10, each separated by exactly one bubble cycle; overflow stays 0000.
